e3_serial_add_ctrl: RTL and testbench

//  Digit-serial sequencer for Excess-3 (E3) decimal addition of two NDIG-digit operands.
//  - Shares one 4-bit digit adder and its E3 correction stage across all digits,
//    one digit per clock, LSD first.
//  - start/busy/done handshake; latches operands; assembles the E3 sum and decimal carry-out.
//  - Sits between operand/control logic and the result register file of the E3 adder datapath.

---
 rtl/e3_serial_add_ctrl_pkg.sv | 23 ++
 rtl/e3_digit_add.sv | 41 ++++
 rtl/e3_serial_add_ctrl.sv | 117 +++++++++++
 tb/tb_e3_serial_add_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/e3_serial_add_ctrl_pkg.sv
// Shared constants, state encoding and bit-level helpers for the Excess-3 serial adder.
package e3_serial_add_ctrl_pkg;

    localparam logic [3:0] E3_BIAS = 4'd3;
    localparam logic [3:0] E3_MIN  = 4'h3;
    localparam logic [3:0] E3_MAX  = 4'hC;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // One full-adder cell: returns {carry, sum}.
    function automatic logic [1:0] fac(input logic x, input logic y, input logic ci);
        return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
    endfunction

    function automatic logic digit_invalid(input logic [3:0] d);
        return (d < E3_MIN) || (d > E3_MAX);
    endfunction

endpackage

// File: rtl/e3_digit_add.sv
// Single Excess-3 digit adder: binary ripple of full adders, then +3/-3 correction ripple.
module e3_digit_add
    import e3_serial_add_ctrl_pkg::*;
(
    input  logic [3:0] a4,
    input  logic [3:0] b4,
    input  logic       ci,
    output logic [3:0] d4,
    output logic       co
);

    logic [3:0] raw_lo;
    logic [3:0] corr;
    logic [1:0] fa;
    logic       rc;
    logic       cc;

    // NOTE: every variable gets a default at the top so no path leaves one unassigned (no latch).
    always_comb begin
        raw_lo = '0;
        d4     = '0;
        fa     = '0;
        rc     = ci;
        for (int i = 0; i < 4; i++) begin
            fa        = fac(a4[i], b4[i], rc);
            raw_lo[i] = fa[0];
            rc        = fa[1];
        end
        co = rc;

        // With a decimal carry add the bias back, otherwise subtract it (add two's complement).
        corr = rc ? E3_BIAS : (~E3_BIAS + 4'd1);
        cc   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fa    = fac(raw_lo[i], corr[i], cc);
            d4[i] = fa[0];
            cc    = fa[1];
        end
    end

endmodule

// File: rtl/e3_serial_add_ctrl.sv
// Digit-serial Excess-3 adder sequencer: one shared digit adder, LSD first, start/busy/done.
module e3_serial_add_ctrl
    import e3_serial_add_ctrl_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [4*NDIG-1:0] a,
    input  logic [4*NDIG-1:0] b,
    input  logic              cin,
    output logic              busy,
    output logic              done,
    output logic [4*NDIG-1:0] sum,
    output logic              cout,
    output logic              err
);

    localparam int W  = 4 * NDIG;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            err_q, err_d;

    logic [3:0]      a_dig, b_dig, d_dig;
    logic            c_dig;

    assign a_dig = a_q[{idx_q, 2'b00} +: 4];
    assign b_dig = b_q[{idx_q, 2'b00} +: 4];

    e3_digit_add u_digit (
        .a4 (a_dig),
        .b4 (b_dig),
        .ci (carry_q),
        .d4 (d_dig),
        .co (c_dig)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        err_d   = err_q;
        busy    = 1'b0;
        done    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    err_d   = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                busy                         = 1'b1;
                sum_d[{idx_q, 2'b00} +: 4]   = d_dig;
                carry_d                      = c_dig;
                err_d = err_q | digit_invalid(a_dig) | digit_invalid(b_dig);
                if (idx_q == IW'(NDIG - 1)) begin
                    cout_d  = c_dig;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so all flops update together at the edge.
    // Operand latches are reset too: they are plain registers, not a memory array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign err  = err_q;

endmodule

// File: tb/tb_e3_serial_add_ctrl.sv
// Directed-vector bench for the Excess-3 serial adder sequencer (NDIG=4).
module tb_e3_serial_add_ctrl;

    localparam int NDIG = 4;
    localparam int W    = 4 * NDIG;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy, done, cout, err;
    logic [W-1:0] sum;

    int errors = 0;
    int checks = 0;

    e3_serial_add_ctrl #(.NDIG(NDIG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .err   (err)
    );

    always #5 clk = ~clk;

    // Drive operands at a negedge and hold start across exactly one rising edge.
    task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci);
        @(negedge clk);
        a = av; b = bv; cin = ci; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        a = '0; b = '0; cin = 1'b0;
    endtask

    // Count negedges until done (bounded); busy_cycles counts negedges with busy high.
    task automatic wait_done(output int cycles, output int busy_cycles);
        cycles = 0; busy_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cycles++;
            if (busy) busy_cycles++;
            if (done) return;
        end
        cycles = -1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if ({sum, cout, err} !== '0) begin errors++; $display("FAIL reset_outputs got %h/%b/%b exp 0", sum, cout, err); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat, bc;
        launch(16'h4567, 16'h89AB, 1'b0);
        wait_done(lat, bc);
        checks++; if (lat !== 5) begin errors++; $display("FAIL basic_latency got %0d exp 5", lat); end
        checks++; if (sum !== 16'h9C45) begin errors++; $display("FAIL basic_sum got %h exp 9c45", sum); end
        checks++; if (cout !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL basic_flags got cout=%b err=%b exp 0/0", cout, err); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b exp 0", done); end
    endtask

    task automatic test_all_nines();
        int lat, bc;
        launch(16'hCCCC, 16'hCCCC, 1'b1);
        wait_done(lat, bc);
        checks++; if (sum !== 16'hCCCC) begin errors++; $display("FAIL nines_sum got %h exp cccc", sum); end
        checks++; if (cout !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL nines_flags got cout=%b err=%b exp 1/0", cout, err); end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        launch(16'h3333, 16'h3333, 1'b0);
        wait_done(lat, bc);
        checks++; if (sum !== 16'h3333 || cout !== 1'b0) begin errors++; $display("FAIL b2b_first got %h/%b exp 3333/0", sum, cout); end
        // Request the next operation while still in DONE; it is taken from IDLE.
        a = 16'h3333; b = 16'h3333; cin = 1'b1; start = 1'b1;
        wait_done(lat, bc);
        start = 1'b0; a = '0; b = '0; cin = 1'b0;
        checks++; if (lat !== 6) begin errors++; $display("FAIL b2b_period got %0d exp 6", lat); end
        checks++; if (sum !== 16'h3334 || cout !== 1'b0) begin errors++; $display("FAIL b2b_second got %h/%b exp 3334/0", sum, cout); end
        @(negedge clk);
    endtask

    task automatic test_invalid();
        int lat, bc;
        launch(16'h333F, 16'h3333, 1'b0);
        wait_done(lat, bc);
        checks++; if (lat !== 5) begin errors++; $display("FAIL invalid_latency got %0d exp 5", lat); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL invalid_err got %b exp 1", err); end
        checks++; if (sum !== 16'h3345 || cout !== 1'b0) begin errors++; $display("FAIL invalid_sum got %h/%b exp 3345/0", sum, cout); end
        launch(16'h4567, 16'h89AB, 1'b0);
        wait_done(lat, bc);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL invalid_err_clear got %b exp 0", err); end
    endtask

    task automatic test_ignore_start();
        int lat, bc, extra;
        launch(16'h4567, 16'h89AB, 1'b0);
        @(negedge clk);
        a = 16'hCCCC; b = 16'hCCCC; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = '0; b = '0; cin = 1'b0;
        wait_done(lat, bc);
        checks++; if (lat + 2 !== 5) begin errors++; $display("FAIL ignore_latency got %0d exp 5", lat + 2); end
        checks++; if (bc + 2 !== 4) begin errors++; $display("FAIL ignore_busy_cycles got %0d exp 4", bc + 2); end
        checks++; if (sum !== 16'h9C45 || cout !== 1'b0) begin errors++; $display("FAIL ignore_sum got %h/%b exp 9c45/0", sum, cout); end
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (busy || done) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL ignore_no_queue got %0d busy/done cycles exp 0", extra); end
    endtask

    task automatic test_reset_mid_run();
        int lat, bc, seen;
        launch(16'hCCCC, 16'hCCCC, 1'b1);
        wait_done(lat, bc);
        launch(16'h4567, 16'h89AB, 1'b0);
        @(negedge clk); @(negedge clk); @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_precond_busy got %b exp 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_ctrl got busy=%b done=%b exp 0/0", busy, done); end
        checks++; if ({sum, cout, err} !== '0) begin errors++; $display("FAIL midrst_outputs got %h/%b/%b exp 0", sum, cout, err); end
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_done got %0d active cycles exp 0", seen); end
        launch(16'h4567, 16'h89AB, 1'b0);
        wait_done(lat, bc);
        checks++; if (lat !== 5 || sum !== 16'h9C45) begin errors++; $display("FAIL midrst_recover got lat=%0d sum=%h exp 5/9c45", lat, sum); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_all_nines();
        test_back_to_back();
        test_invalid();
        test_ignore_start();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
